imem_loader: RTL
================

Name: imem_loader

Overview:
- Byte-stream program loader. It is the writer on the instruction/data BRAM port whose reader is the pipelined core's fetch port.
- Accepts framed bytes from a UART receiver over a valid/ready handshake and assembles them into little-endian 32-bit words.
- Writes each word to BRAM at consecutive word indices starting at 0.
- Holds the core in reset until a frame completes with a valid checksum.

Parameters:
- ADDR_W, 13, BRAM word-index width; capacity 2**ADDR_W words.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rx_valid  in  1  byte available from UART receiver.
- rx_data  in  8  received byte.
- rx_ready  out  1  loader can accept a byte; a byte transfers when rx_valid && rx_ready.
- mem_we  out  4  BRAM byte write enables; 4'hF or 4'h0 only.
- mem_addr  out  ADDR_W  BRAM word index.
- mem_din  out  32  BRAM write data.
- core_rst_n  out  1  active-low reset to the core; low while loading or errored.
- busy  out  1  frame in progress.
- done  out  1  last frame loaded and checksum OK.
- err  out  1  last frame failed (bad length or checksum).
- word_cnt  out  ADDR_W+1  words written in the current frame.

Behaviour:
- All outputs are registered.
- Reset values, applied asynchronously while rst=1:
  - state=IDLE, rx_ready=0, mem_we=0, mem_addr=0, mem_din=0.
  - core_rst_n=0, busy=0, done=0, err=0, word_cnt=0, len=0, csum=0, byte_idx=0.
- rx_ready goes to 1 on the first clk edge after rst deasserts.
- States: IDLE, LEN_LO, LEN_HI, DATA, WRITE, CSUM, DONE, ERR.
- IDLE/DONE/ERR:
  - An accepted byte == SYNC_BYTE goes to LEN_LO; clear csum, word_cnt and byte_idx; set busy=1; clear done and err; core_rst_n=0 on the next edge.
  - Any other byte is accepted and discarded.
- LEN_LO: accepted byte goes to len[7:0]; csum+=byte; next state LEN_HI.
- LEN_HI: accepted byte goes to len[15:8]; csum+=byte. Then:
  - len > 2**ADDR_W: go to ERR.
  - len == 0: go to CSUM.
  - otherwise: go to DATA.
- DATA:
  - Accepted byte goes to mem_din[8*byte_idx+7 -: 8]; csum+=byte; byte_idx++ (2-bit wrap).
  - On the 4th byte (byte_idx==3), go to WRITE.
- WRITE (exactly one cycle):
  - mem_we=4'hF, mem_addr=word_cnt[ADDR_W-1:0], mem_din=assembled word.
  - rx_ready=0; no byte is accepted.
  - Next edge: mem_we=0; word_cnt++. If word_cnt+1 == len go to CSUM, else go to DATA.
- Write timing: latency from the 4th data byte's handshake edge to mem_we high is 1 cycle.
- mem_addr and mem_din hold their values after the write; mem_we is the only strobe.
- CSUM: accepted byte added to csum (mod 256).
  - Total == 0: go to DONE; done=1, busy=0, core_rst_n=1 on the same edge.
  - Otherwise: go to ERR; err=1, busy=0, core_rst_n stays 0.
- Checksum arithmetic: 8-bit wraparound over LEN_LO, LEN_HI, all data bytes and the checksum byte.
- done and err are mutually exclusive. Each is sticky until the next SYNC_BYTE or rst.
- A SYNC_BYTE value received inside a frame (LEN/DATA/CSUM) is ordinary data; there is no resynchronisation.
- rx_valid with rx_ready=0 transfers nothing. The byte must be held by the source and is taken the following cycle.
- Reset mid-frame aborts immediately:
  - Words already written stay in BRAM.
  - A partial word is never written.
- len == 2**ADDR_W fills memory; the final write is at index 2**ADDR_W-1, and word_cnt reaching 2**ADDR_W needs the ADDR_W+1 bit.
- rx_ready is 1 in all states except WRITE and during reset.

Decomposition:
- Shared header (loader_defs): state encodings, SYNC_BYTE default, frame field widths. The core top will reuse the BRAM width constants from it.
- No sub-module is warranted: FSM, word assembler and checksum accumulator stay in one module.
- Integration: the core top muxes the BRAM port B write controls (wea/web) to the loader while core_rst_n=0.

Test Plan:
- Byte stream A5 02 00 13 00 00 00 93 00 10 00 48 ->
  - writes 0x00000013 at index 0 and 0x00100093 at index 1, each with mem_we=4'hF for 1 cycle;
  - then done=1, core_rst_n=1, err=0, word_cnt=2.
- Same frame with the checksum byte changed to 0x49 -> err=1, done=0, core_rst_n=0; two writes still occurred.
- Byte stream 77 A5 00 00 00 -> leading 0x77 ignored; len=0 and checksum 00 gives done=1 with no mem_we pulse.
- Byte stream A5 01 21 (len=0x2101 > 8192) -> err=1 right after LEN_HI, no writes; a following SYNC_BYTE restarts with err=0, busy=1.
- rx_valid held high continuously through a 1-word frame -> rx_ready=0 exactly on the WRITE cycle. No byte is lost or duplicated, and the checksum still passes.
- rst pulsed after 2 data bytes of word 1 -> all outputs at reset values asynchronously; word 0 stays in BRAM and index 1 is never written.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
//   Shared definitions for the byte-stream program loader and the core top
//   that shares the instruction/data BRAM with it.
//   - FSM state encoding of the loader
//   - default frame start marker and BRAM word-index width
//   - frame field widths (byte, length field, BRAM word)
//   - byte-enable patterns for the BRAM write port
// -----------------------------------------------------------------------------
package imem_loader_pkg;

  // BRAM geometry; the core top reuses these for its fetch port.
  localparam int LOADER_ADDR_W = 13;
  localparam int WORD_W        = 32;

  // Frame fields.
  localparam int               BYTE_W           = 8;
  localparam int               LEN_W            = 16;
  localparam logic [BYTE_W-1:0] LOADER_SYNC_BYTE = 8'hA5;

  // The loader only ever writes whole words.
  localparam logic [3:0] WE_WORD = 4'hF;
  localparam logic [3:0] WE_NONE = 4'h0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_WRITE,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_t;

  // 8-bit wraparound checksum accumulation.
  function automatic logic [BYTE_W-1:0] csum_add(input logic [BYTE_W-1:0] acc,
                                                 input logic [BYTE_W-1:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//   Receives a framed byte stream from a UART receiver, assembles
//   little-endian 32-bit words and writes them to consecutive BRAM word
//   indices starting at 0. The core is held in reset until a frame completes
//   with a valid checksum.
//
//   Frame: SYNC_BYTE, LEN_LO, LEN_HI, 4*len data bytes, checksum byte.
//   The 8-bit sum of LEN_LO, LEN_HI, data and checksum bytes must be 0.
//
// Ports
//   clk         in   system clock, rising edge
//   rst         in   asynchronous, active-high reset
//   rx_valid    in   byte available from UART receiver
//   rx_data     in   received byte
//   rx_ready    out  byte accepted when rx_valid && rx_ready
//   mem_we      out  BRAM byte enables (4'hF for one cycle per word)
//   mem_addr    out  BRAM word index
//   mem_din     out  BRAM write data
//   core_rst_n  out  active-low core reset; released only after a good frame
//   busy        out  frame in progress
//   done        out  last frame loaded with good checksum (sticky)
//   err         out  last frame had a bad length or checksum (sticky)
//   word_cnt    out  words written in the current frame
// -----------------------------------------------------------------------------
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int                ADDR_W    = LOADER_ADDR_W,
  parameter logic [BYTE_W-1:0] SYNC_BYTE = LOADER_SYNC_BYTE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rx_valid,
  input  logic [BYTE_W-1:0]   rx_data,
  output logic                rx_ready,
  output logic [3:0]          mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [WORD_W-1:0]   mem_din,
  output logic                core_rst_n,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [ADDR_W:0]     word_cnt
);

  // Largest legal length: a frame may fill the whole BRAM.
  localparam logic [LEN_W:0] MAX_LEN = (LEN_W+1)'(1) << ADDR_W;

  state_t              state, state_nxt;
  logic [LEN_W-1:0]    len, len_nxt;
  logic [BYTE_W-1:0]   csum, csum_nxt;
  logic [1:0]          byte_idx, byte_idx_nxt;

  logic                rx_ready_nxt;
  logic [3:0]          mem_we_nxt;
  logic [ADDR_W-1:0]   mem_addr_nxt;
  logic [WORD_W-1:0]   mem_din_nxt;
  logic                core_rst_n_nxt;
  logic                busy_nxt;
  logic                done_nxt;
  logic                err_nxt;
  logic [ADDR_W:0]     word_cnt_nxt;

  logic                accept;
  logic [LEN_W-1:0]    len_full;
  logic [BYTE_W-1:0]   csum_sum;
  logic [ADDR_W:0]     word_cnt_inc;

  assign accept       = rx_valid && rx_ready;
  assign len_full     = {rx_data, len[BYTE_W-1:0]};
  assign csum_sum     = csum_add(csum, rx_data);
  assign word_cnt_inc = word_cnt + (ADDR_W+1)'(1);

  // NOTE: every variable gets its hold/default value before the case
  // statement, so no path through the block leaves one unassigned and no
  // latch is inferred.
  always_comb begin
    state_nxt      = state;
    len_nxt        = len;
    csum_nxt       = csum;
    byte_idx_nxt   = byte_idx;
    mem_we_nxt     = WE_NONE;
    mem_addr_nxt   = mem_addr;
    mem_din_nxt    = mem_din;
    core_rst_n_nxt = core_rst_n;
    busy_nxt       = busy;
    done_nxt       = done;
    err_nxt        = err;
    word_cnt_nxt   = word_cnt;

    case (state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        // Non-sync bytes are accepted and dropped.
        if (accept && rx_data == SYNC_BYTE) begin
          state_nxt      = ST_LEN_LO;
          csum_nxt       = '0;
          word_cnt_nxt   = '0;
          byte_idx_nxt   = '0;
          busy_nxt       = 1'b1;
          done_nxt       = 1'b0;
          err_nxt        = 1'b0;
          core_rst_n_nxt = 1'b0;
        end
      end

      ST_LEN_LO: begin
        if (accept) begin
          len_nxt[BYTE_W-1:0] = rx_data;
          csum_nxt            = csum_sum;
          state_nxt           = ST_LEN_HI;
        end
      end

      ST_LEN_HI: begin
        if (accept) begin
          len_nxt  = len_full;
          csum_nxt = csum_sum;
          if ({1'b0, len_full} > MAX_LEN) begin
            state_nxt = ST_ERR;
            err_nxt   = 1'b1;
            busy_nxt  = 1'b0;
          end else if (len_full == '0) begin
            state_nxt = ST_CSUM;
          end else begin
            state_nxt = ST_DATA;
          end
        end
      end

      ST_DATA: begin
        if (accept) begin
          // Little-endian: first byte of a word lands in bits [7:0].
          mem_din_nxt[{byte_idx, 3'b000} +: BYTE_W] = rx_data;
          csum_nxt     = csum_sum;
          byte_idx_nxt = byte_idx + 2'd1;
          if (byte_idx == 2'd3) begin
            state_nxt    = ST_WRITE;
            mem_we_nxt   = WE_WORD;
            mem_addr_nxt = word_cnt[ADDR_W-1:0];
          end
        end
      end

      ST_WRITE: begin
        word_cnt_nxt = word_cnt_inc;
        if ((LEN_W+1)'(word_cnt_inc) == {1'b0, len}) state_nxt = ST_CSUM;
        else                                          state_nxt = ST_DATA;
      end

      ST_CSUM: begin
        if (accept) begin
          csum_nxt = csum_sum;
          busy_nxt = 1'b0;
          if (csum_sum == '0) begin
            state_nxt      = ST_DONE;
            done_nxt       = 1'b1;
            core_rst_n_nxt = 1'b1;
          end else begin
            state_nxt = ST_ERR;
            err_nxt   = 1'b1;
          end
        end
      end

      default: state_nxt = ST_IDLE;
    endcase

    // The write cycle is the only one in which no byte is taken.
    rx_ready_nxt = (state_nxt != ST_WRITE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      len        <= '0;
      csum       <= '0;
      byte_idx   <= '0;
      rx_ready   <= 1'b0;
      mem_we     <= WE_NONE;
      mem_addr   <= '0;
      mem_din    <= '0;
      core_rst_n <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      word_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      len        <= len_nxt;
      csum       <= csum_nxt;
      byte_idx   <= byte_idx_nxt;
      rx_ready   <= rx_ready_nxt;
      mem_we     <= mem_we_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_din    <= mem_din_nxt;
      core_rst_n <= core_rst_n_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      err        <= err_nxt;
      word_cnt   <= word_cnt_nxt;
    end
  end

endmodule
